// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer of {pc, instr} entries with synchronous flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  fetch_entry_t mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: readers only look at it while the buffer is non-empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with prefetch buffer, redirect and fault stop
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  fetch_state_t state, state_next;
  logic [31:0]  fetch_pc, fetch_pc_next;
  logic [31:0]  fault_pc_next;

  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t fifo_head;
  fetch_entry_t push_entry;
  logic         pop;
  logic         issue;
  logic         push;

  assign imem_addr = fetch_pc;
  assign pop       = out_valid && out_ready;
  // A full buffer can still take a fetch when the head leaves on the same edge.
  assign issue     = (state == RUN) && !redirect_valid && (!fifo_full || pop);
  assign push      = issue && imem_valid;

  assign push_entry.pc    = fetch_pc;
  assign push_entry.instr = imem_data;

  assign out_valid = !fifo_empty;
  assign out_instr = fifo_empty ? FETCH_NOP : fifo_head.instr;
  assign out_pc    = fifo_empty ? 32'h0 : fifo_head.pc;
  assign fault     = (state == FAULT);

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    fault_pc_next = fault_pc;
    if (redirect_valid) begin
      state_next    = RUN;
      fetch_pc_next = redirect_pc;
    end else if (issue) begin
      if (imem_valid) begin
        fetch_pc_next = fetch_pc + 32'd4;
      end else begin
        state_next    = FAULT;
        fault_pc_next = fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      fetch_pc <= BASE_ADDR;
      fault_pc <= 32'h0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      fault_pc <= fault_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  logic        bad_en;
  logic [31:0] bad_addr;
  int          err_cnt;
  int          chk_cnt;

  fetch_unit #(
    .BASE_ADDR (32'h8000_0000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_valid    (imem_valid),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns addr ^ A5A55A5A; aligned addresses are valid unless the bad address is armed.
  assign imem_data  = imem_addr ^ 32'hA5A5_5A5A;
  assign imem_valid = (imem_addr[1:0] == 2'b00) && !(bad_en && (imem_addr == bad_addr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    bad_en         = 1'b0;
    bad_addr       = 32'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;

    // Reset state
    do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_instr", out_instr, 32'h0000_0013);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h8000_0000);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_fault_pc", fault_pc, 32'h0);

    // Streaming with consumer always ready
    do_reset();
    out_ready = 1'b1;
    step();
    check("str_valid0", {31'h0, out_valid}, 32'h1);
    check("str_pc0", out_pc, 32'h8000_0000);
    check("str_instr0", out_instr, 32'h25A5_5A5A);
    step();
    check("str_pc1", out_pc, 32'h8000_0004);
    check("str_instr1", out_instr, 32'h25A5_5A5E);
    step();
    check("str_pc2", out_pc, 32'h8000_0008);
    check("str_addr2", imem_addr, 32'h8000_000C);

    // Back-pressure: buffer fills to 4 and fetch stalls
    do_reset();
    for (int i = 0; i < 10; i++) step();
    check("bp_addr", imem_addr, 32'h8000_0010);
    check("bp_head", out_pc, 32'h8000_0000);
    check("bp_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("bp_drain%0d", i), out_pc, 32'h8000_0000 + 32'(i * 4));
    end

    // Invalid access at 0x8000_0008 stops fetch, buffer still drains
    do_reset();
    bad_en   = 1'b1;
    bad_addr = 32'h8000_0008;
    step();
    step();
    check("flt_before", {31'h0, fault}, 32'h0);
    step();
    check("flt_fault", {31'h0, fault}, 32'h1);
    check("flt_fault_pc", fault_pc, 32'h8000_0008);
    check("flt_addr", imem_addr, 32'h8000_0008);
    check("flt_head0", out_pc, 32'h8000_0000);
    out_ready = 1'b1;
    step();
    check("flt_head1", out_pc, 32'h8000_0004);
    step();
    check("flt_empty", {31'h0, out_valid}, 32'h0);
    check("flt_nop", out_instr, 32'h0000_0013);
    check("flt_pc0", out_pc, 32'h0);
    step();
    check("flt_hold_addr", imem_addr, 32'h8000_0008);
    check("flt_hold", {31'h0, fault}, 32'h1);

    // Redirect out of FAULT clears it
    bad_en         = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    check("rdf_fault", {31'h0, fault}, 32'h0);
    check("rdf_addr", imem_addr, 32'h8000_0100);
    check("rdf_empty", {31'h0, out_valid}, 32'h0);
    step();
    check("rdf_pc", out_pc, 32'h8000_0100);

    // Redirect while full and popping flushes stale entries
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("rdb_full_addr", imem_addr, 32'h8000_0010);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    check("rdb_flushed", {31'h0, out_valid}, 32'h0);
    check("rdb_addr", imem_addr, 32'h8000_0100);
    step();
    check("rdb_pc", out_pc, 32'h8000_0100);
    step();
    check("rdb_pc_next", out_pc, 32'h8000_0104);

    // Misaligned redirect faults one cycle later
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    check("mis_nofault_yet", {31'h0, fault}, 32'h0);
    step();
    check("mis_fault", {31'h0, fault}, 32'h1);
    check("mis_fault_pc", fault_pc, 32'h8000_0102);
    check("mis_empty", {31'h0, out_valid}, 32'h0);

    // Address wraps modulo 2^32
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap_addr", imem_addr, 32'h0000_0000);
    check("wrap_pc", out_pc, 32'hFFFF_FFFC);

    // Asynchronous reset mid-operation with 3 buffered entries
    do_reset();
    for (int i = 0; i < 3; i++) step();
    check("ar_addr_before", imem_addr, 32'h8000_000C);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'h0, out_valid}, 32'h0);
    check("ar_addr", imem_addr, 32'h8000_0000);
    check("ar_pc", out_pc, 32'h0);
    step();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter BASE_ADDR, default 32'h8000_0000: reset fetch PC.
REQ-002 Parameter FIFO_DEPTH, default 4: prefetch buffer entries, power of two, minimum 2.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_addr  output  32  fetch byte address to the instruction memory.
REQ-006 imem_data  input  32  instruction word, combinationally returned for imem_addr.
REQ-007 imem_valid  input  1  imem_data valid: address aligned and in range.
REQ-008 redirect_valid  input  1  flush and restart fetch at redirect_pc.
REQ-009 redirect_pc  input  32  new fetch PC.
REQ-010 out_valid  output  1  buffered instruction available.
REQ-011 out_ready  input  1  consumer accepts the head entry.
REQ-012 out_instr  output  32  head instruction word.
REQ-013 out_pc  output  32  head instruction PC.
REQ-014 fault  output  1  fetch stopped on an invalid access.
REQ-015 fault_pc  output  32  address of the invalid access.

Function
REQ-016 imem_addr SHALL equal the registered fetch_pc at all times; no combinational path from any input to imem_addr.
REQ-017 State machine SHALL have two states: RUN and FAULT.
REQ-018 pop SHALL equal out_valid AND out_ready; an entry leaves the buffer on that clock edge.
REQ-019 In RUN with no redirect, a fetch SHALL issue when count < FIFO_DEPTH or pop is high; full with simultaneous pop SHALL still fetch.
REQ-020 An issued fetch with imem_valid=1 SHALL push {fetch_pc, imem_data} and advance fetch_pc by 4, wrapping modulo 2^32.
REQ-021 An issued fetch with imem_valid=0 SHALL push nothing, hold fetch_pc, capture fault_pc=fetch_pc and enter FAULT.
REQ-022 With no fetch issued, the buffer and fetch_pc SHALL hold and imem_valid SHALL be ignored.
REQ-023 In FAULT, fault SHALL be 1 and no fetch SHALL issue; buffered entries SHALL continue to drain normally.
REQ-024 redirect_valid=1, in either state, SHALL on the same edge empty the buffer, set fetch_pc=redirect_pc, enter RUN, and push nothing.
REQ-025 Redirect SHALL take precedence over push and pop in the same cycle; the popped head counts as consumed.
REQ-026 A misaligned or out-of-range redirect_pc SHALL fault one cycle later under REQ-021.
REQ-027 out_valid SHALL be 1 iff count != 0; out_instr and out_pc SHALL be the head entry and hold while out_valid=1 and out_ready=0.
REQ-028 Latency: an instruction fetched at edge N SHALL be presented on out_* after edge N, one cycle after its address.
REQ-029 With out_ready held high and no faults, sustained throughput SHALL be one instruction per cycle.
REQ-030 When out_valid=0, out_instr SHALL read FETCH_NOP (32'h0000_0013) and out_pc SHALL read 0.

Reset
REQ-031 While reset=0, the block SHALL hold: fetch_pc=BASE_ADDR, state=RUN, count=0, fault=0, fault_pc=0, out_valid=0, out_instr=FETCH_NOP, out_pc=0.
REQ-032 Reset assertion mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-033 The first fetch SHALL issue in the first cycle after reset deasserts.

Structure
REQ-034 Shared package SHALL hold fetch_state_t (RUN, FAULT), the fetch_entry_t struct {pc, instr}, and the FETCH_NOP constant.
REQ-035 The buffer SHALL be a sub-module fetch_fifo: parameterised depth, push, pop, flush, full, empty, head, and pointers sized $clog2(FIFO_DEPTH)+1.
REQ-036 Target size: 150-300 lines RTL total.

Verification
REQ-037 Reset release, out_ready=1, memory valid: out_pc=0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles, first one cycle after release.
REQ-038 out_ready=0 for 10 cycles: exactly 4 entries buffered and imem_addr frozen at 0x8000_0010; then out_ready=1 delivers 0x8000_0000 through 0x8000_000C, then one instruction per cycle.
REQ-039 imem_valid=0 at 0x8000_0008: fault=1 with fault_pc=0x8000_0008 next cycle; 0x8000_0000 and 0x8000_0004 still drain; no further address change.
REQ-040 redirect to 0x8000_0100 while the buffer is full and popping: next out_pc=0x8000_0100 with no stale entry; redirect in FAULT clears fault.
REQ-041 redirect to 0x8000_0102: fault=1 and fault_pc=0x8000_0102 one cycle later, out_valid=0.
REQ-042 reset=0 asserted between clock edges with 3 buffered entries: out_valid=0 and imem_addr=0x8000_0000 immediately.
